// File: rtl/pwm_pkg.sv
// pwm_pkg: types and default widths shared by the PWM timebase and the
// per-channel dead-time stage.
package pwm_pkg;

    localparam int PWM_CNT_WIDTH = 32;
    localparam int PWM_DT_WIDTH  = 8;

    typedef enum logic [2:0] {
        S_OFF,
        S_DEAD_TO_HIGH,
        S_HIGH,
        S_DEAD_TO_LOW,
        S_LOW
    } pwm_dt_state_t;

    // Moore decode of the high-side drive.
    function automatic logic drives_high(input pwm_dt_state_t s);
        return (s == S_HIGH);
    endfunction

    // Moore decode of the low-side drive.
    function automatic logic drives_low(input pwm_dt_state_t s);
        return (s == S_LOW);
    endfunction

endpackage

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: turns the raw PWM compare into a complementary high/low
// drive pair separated by a programmable dead band. Both drives are
// registered Moore outputs of the state, so they can never be high together.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = PWM_DT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pwm_raw,
    input  logic [DT_WIDTH-1:0] dead_cycles,
    output logic                pwm_h,
    output logic                pwm_l
);

    pwm_dt_state_t       state_q, state_d;
    logic [DT_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
    logic                pwm_h_q, pwm_l_q;
    logic                dead_zero;

    assign dead_zero = (dead_cycles == '0);

    // Next state and dead-band count; a zero dead band jumps straight to the drive state.
    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        if (!enable) begin
            state_d  = S_OFF;
            dt_cnt_d = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    // Even a start from off waits out a full dead band.
                    if (pwm_raw) state_d = dead_zero ? S_HIGH : S_DEAD_TO_HIGH;
                    else         state_d = dead_zero ? S_LOW  : S_DEAD_TO_LOW;
                    dt_cnt_d = dead_cycles;
                end
                S_LOW: begin
                    if (pwm_raw) begin
                        state_d  = dead_zero ? S_HIGH : S_DEAD_TO_HIGH;
                        dt_cnt_d = dead_cycles;
                    end
                end
                S_HIGH: begin
                    if (!pwm_raw) begin
                        state_d  = dead_zero ? S_LOW : S_DEAD_TO_LOW;
                        dt_cnt_d = dead_cycles;
                    end
                end
                S_DEAD_TO_HIGH: begin
                    // Both drives are already low, so a reverting request may
                    // return to the low side without another dead band.
                    if (!pwm_raw) begin
                        state_d  = S_LOW;
                        dt_cnt_d = '0;
                    end else if (dt_cnt_q <= DT_WIDTH'(1)) begin
                        state_d  = S_HIGH;
                        dt_cnt_d = '0;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
                    end
                end
                S_DEAD_TO_LOW: begin
                    if (pwm_raw) begin
                        state_d  = S_HIGH;
                        dt_cnt_d = '0;
                    end else if (dt_cnt_q <= DT_WIDTH'(1)) begin
                        state_d  = S_LOW;
                        dt_cnt_d = '0;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d  = S_OFF;
                    dt_cnt_d = '0;
                end
            endcase
        end
    end

    // State, counter and registered drive outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_OFF;
            dt_cnt_q <= '0;
            pwm_h_q  <= 1'b0;
            pwm_l_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
            pwm_h_q  <= drives_high(state_d);
            pwm_l_q  <= drives_low(state_d);
        end
    end

    assign pwm_h = pwm_h_q;
    assign pwm_l = pwm_l_q;

endmodule

// File: rtl/pwm_deadtime_channel.sv
// pwm_deadtime_channel: one half-bridge leg fed by the shared timebase.
// Holds the period-aligned duty shadow and the compare, then hands the raw
// waveform to pwm_deadtime_gen for complementary drive with dead band.
// Optional latched fault shutdown: define PWM_DEADTIME_FAULT_EN.
module pwm_deadtime_channel
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = PWM_CNT_WIDTH,
    parameter int DT_WIDTH  = PWM_DT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic                 period_end,
    input  logic [CNT_WIDTH-1:0] duty_cycles,
    input  logic [DT_WIDTH-1:0]  dead_cycles,
    output logic                 pwm_raw,
    output logic                 pwm_h,
    output logic                 pwm_l,
    output logic [CNT_WIDTH-1:0] duty_active
`ifdef PWM_DEADTIME_FAULT_EN
    ,
    input  logic                 fault_in,
    output logic                 fault_latched
`endif
);

    logic [CNT_WIDTH-1:0] duty_active_q, duty_active_d;
    logic                 pwm_raw_q, pwm_raw_d;
    logic                 gen_enable;

    // Shadow loads only at a period boundary (or while idle) so a running
    // period is never cut short; the compare still sees the old shadow on
    // the boundary edge, so the new duty first applies to cnt=0.
    always_comb begin
        duty_active_d = (!enable || period_end) ? duty_cycles : duty_active_q;
        pwm_raw_d     = enable && (cnt < duty_active_q);
    end

    // Shadow duty and registered compare result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_active_q <= '0;
            pwm_raw_q     <= 1'b0;
        end else begin
            duty_active_q <= duty_active_d;
            pwm_raw_q     <= pwm_raw_d;
        end
    end

`ifdef PWM_DEADTIME_FAULT_EN
    logic fault_q, fault_d;

    // Sticky fault; it clears only once the channel is disabled and the fault source is gone.
    always_comb begin
        if (fault_in)     fault_d = 1'b1;
        else if (!enable) fault_d = 1'b0;
        else              fault_d = fault_q;
    end

    // Fault latch register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end

    assign fault_latched = fault_q;
    assign gen_enable    = enable && !fault_q;
`else
    assign gen_enable    = enable;
`endif

    pwm_deadtime_gen #(
        .DT_WIDTH (DT_WIDTH)
    ) u_gen (
        .clk         (clk),
        .rst         (rst),
        .enable      (gen_enable),
        .pwm_raw     (pwm_raw_q),
        .dead_cycles (dead_cycles),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l)
    );

    assign pwm_raw     = pwm_raw_q;
    assign duty_active = duty_active_q;

endmodule

// File: tb/tb_pwm_deadtime_channel.sv
// Bench for pwm_deadtime_channel: a period-10 timebase drives the channel,
// expectations are queued per cycle and compared after the following edge,
// and each scenario task adds its own period-level checks.
module tb_pwm_deadtime_channel;

    localparam int CW     = 32;
    localparam int DW     = 8;
    localparam int PERIOD = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [CW-1:0] cnt;
    logic          period_end;
    logic [CW-1:0] duty_cycles;
    logic [DW-1:0] dead_cycles;
    logic          pwm_raw, pwm_h, pwm_l;
    logic [CW-1:0] duty_active;
`ifdef PWM_DEADTIME_FAULT_EN
    logic          fault_in = 1'b0;
    logic          fault_latched;
`endif

    pwm_deadtime_channel #(.CNT_WIDTH(CW), .DT_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cnt         (cnt),
        .period_end  (period_end),
        .duty_cycles (duty_cycles),
        .dead_cycles (dead_cycles),
        .pwm_raw     (pwm_raw),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l),
        .duty_active (duty_active)
`ifdef PWM_DEADTIME_FAULT_EN
        ,
        .fault_in      (fault_in),
        .fault_latched (fault_latched)
`endif
    );

    always #5 clk = ~clk;

    ap_no_overlap: assert property (@(negedge clk) !(pwm_h && pwm_l))
        else $error("FAIL overlap pwm_h=%b pwm_l=%b", pwm_h, pwm_l);

    typedef struct {
        int            cyc;
        logic          raw;
        logic          h;
        logic          l;
        logic [CW-1:0] duty;
        int            mode;
    } exp_t;

    exp_t          sb[$];
    logic          en_hist[$];
    logic          raw_hist[$];
    logic [CW-1:0] m_shadow;
    logic          m_raw_cur;
    int            hl_mode;   // 0: dead-band window, 1: short-pulse pattern, 2: drives unchecked
    int            cyc;
    int            errors;
    int            checks;

    // One clock: queue the expectation for the next edge, advance, compare, step the timebase.
    task automatic cycle();
        exp_t e;
        int   n;
        logic ok_h, ok_l;
        if (rst) begin
            m_shadow  = '0;
            m_raw_cur = 1'b0;
            en_hist.delete();
            raw_hist.delete();
            sb.delete();
        end else begin
            e.raw = enable && (cnt < m_shadow);
            if (!enable || period_end) m_shadow = duty_cycles;
            e.duty = m_shadow;
            en_hist.push_back(enable);
            raw_hist.push_back(m_raw_cur);
            if (en_hist.size() > 32) begin
                void'(en_hist.pop_front());
                void'(raw_hist.pop_front());
            end
            // A side drives once the request has held steadily for dead+1 enabled cycles.
            n    = int'(dead_cycles) + 1;
            ok_h = (en_hist.size() >= n);
            ok_l = ok_h;
            for (int i = 0; i < n && i < en_hist.size(); i++) begin
                ok_h = ok_h && en_hist[en_hist.size()-1-i] && raw_hist[raw_hist.size()-1-i];
                ok_l = ok_l && en_hist[en_hist.size()-1-i] && !raw_hist[raw_hist.size()-1-i];
            end
            if (hl_mode == 1) begin
                // duty 1 / dead 3: only the cycle at cnt=2 is a dead cycle, high side never drives
                ok_h = 1'b0;
                ok_l = (cnt != 1);
            end
            e.h    = ok_h;
            e.l    = ok_l;
            e.mode = hl_mode;
            e.cyc  = cyc + 1;
            m_raw_cur = e.raw;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if (pwm_raw !== e.raw) begin
                errors++;
                $display("FAIL sb_raw cyc=%0d got=%b want=%b", cyc, pwm_raw, e.raw);
            end
            checks++;
            if (duty_active !== e.duty) begin
                errors++;
                $display("FAIL sb_duty cyc=%0d got=%0d want=%0d", cyc, duty_active, e.duty);
            end
            if (e.mode != 2) begin
                checks++;
                if (pwm_h !== e.h || pwm_l !== e.l) begin
                    errors++;
                    $display("FAIL sb_drive cyc=%0d got h=%b l=%b want h=%b l=%b",
                             cyc, pwm_h, pwm_l, e.h, e.l);
                end
            end
        end
        cnt        = (cnt == PERIOD - 1) ? '0 : cnt + 1;
        period_end = (cnt == PERIOD - 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (pwm_raw !== 1'b0 || pwm_h !== 1'b0 || pwm_l !== 1'b0 || duty_active !== '0) begin
            errors++;
            $display("FAIL reset_values got raw=%b h=%b l=%b duty=%0d want all 0",
                     pwm_raw, pwm_h, pwm_l, duty_active);
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (pwm_h !== 1'b0 || pwm_l !== 1'b0) begin
            errors++;
            $display("FAIL disabled_after_reset got h=%b l=%b want 0 0", pwm_h, pwm_l);
        end
    endtask

    task automatic test_dead0();
        int nr, nh, nl;
        dead_cycles = 8'd0; duty_cycles = 32'd4; enable = 1'b1; hl_mode = 2;
        repeat (12) cycle();
        hl_mode = 0;
        nr = 0; nh = 0; nl = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            cycle();
            if (pwm_raw) nr++;
            if (pwm_h) nh++;
            if (pwm_l) nl++;
            checks++;
            if (pwm_h !== ~pwm_l) begin
                errors++;
                $display("FAIL dead0_complement got h=%b l=%b want complements", pwm_h, pwm_l);
            end
        end
        checks++;
        if (nr != 8 || nh != 8 || nl != 12) begin
            errors++;
            $display("FAIL dead0_counts got raw=%0d h=%0d l=%0d want 8 8 12", nr, nh, nl);
        end
    endtask

    task automatic test_dead2();
        int nh, nl, nz;
        dead_cycles = 8'd2; duty_cycles = 32'd4; hl_mode = 2;
        repeat (12) cycle();
        hl_mode = 0;
        nh = 0; nl = 0; nz = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            cycle();
            if (pwm_h) nh++;
            if (pwm_l) nl++;
            if (!pwm_h && !pwm_l) nz++;
        end
        checks++;
        if (nh != 4 || nl != 8 || nz != 8) begin
            errors++;
            $display("FAIL dead2_counts got h=%0d l=%0d both_low=%0d want 4 8 8", nh, nl, nz);
        end
    endtask

    task automatic test_duty_change();
        int nr;
        dead_cycles = 8'd0; duty_cycles = 32'd4; hl_mode = 2;
        repeat (12) cycle();
        hl_mode = 0;
        for (int i = 0; i < 20 && cnt != 3; i++) cycle();
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL sync_cnt3 got=%0d want=3", cnt);
        end
        duty_cycles = 32'd7;
        nr = 0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (pwm_raw) nr++;
            checks++;
            if (duty_active !== ((i == 6) ? 32'd7 : 32'd4)) begin
                errors++;
                $display("FAIL shadow_update step=%0d got=%0d want=%0d",
                         i, duty_active, (i == 6) ? 7 : 4);
            end
        end
        checks++;
        if (nr != 1) begin
            errors++;
            $display("FAIL old_period_tail got raw_high=%0d want=1", nr);
        end
        nr = 0;
        for (int i = 0; i < PERIOD; i++) begin
            cycle();
            if (pwm_raw) nr++;
        end
        checks++;
        if (nr != 7) begin
            errors++;
            $display("FAIL new_period got raw_high=%0d want=7", nr);
        end
    endtask

    task automatic test_boundaries();
        logic [CW-1:0] duties [3];
        duties[0] = 32'd0; duties[1] = 32'd10; duties[2] = 32'd15;
        dead_cycles = 8'd0; hl_mode = 0;
        for (int d = 0; d < 3; d++) begin
            duty_cycles = duties[d];
            repeat (12) cycle();
            for (int i = 0; i < PERIOD; i++) begin
                cycle();
                checks++;
                if (d == 0 && (pwm_raw !== 1'b0 || pwm_l !== 1'b1)) begin
                    errors++;
                    $display("FAIL duty0 got raw=%b l=%b want 0 1", pwm_raw, pwm_l);
                end else if (d != 0 && (pwm_raw !== 1'b1 || pwm_h !== 1'b1)) begin
                    errors++;
                    $display("FAIL duty_full duty=%0d got raw=%b h=%b want 1 1",
                             duties[d], pwm_raw, pwm_h);
                end
            end
        end
    endtask

    task automatic test_abort();
        int nz;
        duty_cycles = 32'd1; dead_cycles = 8'd3; hl_mode = 2;
        repeat (20) cycle();
        hl_mode = 1;
        nz = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            cycle();
            if (!pwm_h && !pwm_l) nz++;
            checks++;
            if (pwm_h !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_high got h=%b want 0", pwm_h);
            end
        end
        checks++;
        if (nz != 3) begin
            errors++;
            $display("FAIL abort_both_low got=%0d want=3", nz);
        end
    endtask

    task automatic test_disable();
        int nz;
        logic seen;
        duty_cycles = 32'd4; dead_cycles = 8'd2; hl_mode = 2;
        repeat (20) cycle();
        hl_mode = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = pwm_h;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_high got h=0 want 1 within 20 cycles");
        end
        enable = 1'b0; duty_cycles = 32'd6;
        cycle();
        checks++;
        if (pwm_h !== 1'b0 || pwm_l !== 1'b0 || pwm_raw !== 1'b0 || duty_active !== 32'd6) begin
            errors++;
            $display("FAIL disable_edge got h=%b l=%b raw=%b duty=%0d want 0 0 0 6",
                     pwm_h, pwm_l, pwm_raw, duty_active);
        end
        repeat (3) cycle();
        for (int i = 0; i < 20 && cnt != 6; i++) cycle();
        enable = 1'b1;
        nz = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (pwm_h || pwm_l) seen = 1'b1;
            else nz++;
        end
        checks++;
        if (!seen || nz != 2 || pwm_l !== 1'b1) begin
            errors++;
            $display("FAIL reenable_dead got low_cycles=%0d l=%b want 2 then l=1", nz, pwm_l);
        end
    endtask

    task automatic test_async_reset();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = pwm_h;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_high_rst got h=0 want 1 within 20 cycles");
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (pwm_raw !== 1'b0 || pwm_h !== 1'b0 || pwm_l !== 1'b0 || duty_active !== '0) begin
            errors++;
            $display("FAIL async_reset got raw=%b h=%b l=%b duty=%0d want all 0",
                     pwm_raw, pwm_h, pwm_l, duty_active);
        end
        cycle();
        cycle();
        checks++;
        if (pwm_h !== 1'b0 || pwm_l !== 1'b0 || duty_active !== '0) begin
            errors++;
            $display("FAIL reset_hold got h=%b l=%b duty=%0d want 0 0 0", pwm_h, pwm_l, duty_active);
        end
        rst = 1'b0;
        hl_mode = 2;
        repeat (5) cycle();
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; hl_mode = 2;
        rst = 1'b1; enable = 1'b0; cnt = '0; period_end = 1'b0;
        duty_cycles = '0; dead_cycles = '0;
        m_shadow = '0; m_raw_cur = 1'b0;
        test_reset();
        test_dead0();
        test_dead2();
        test_duty_change();
        test_boundaries();
        test_abort();
        test_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime_channel.md
Name: pwm_deadtime_channel

Overview:
- Per-channel PWM output stage that sits directly downstream of pwm_timebase and consumes its cnt and period_end.
- Compares cnt against a shadowed duty value to form a raw PWM waveform.
- Drives a complementary high-side/low-side pair with programmable dead time, so the two outputs are never high together.
- One instance per half-bridge leg; all channels share one timebase.

Parameters:
- CNT_WIDTH, 32: width of cnt and duty_cycles; must match the timebase.
- DT_WIDTH, 8: width of dead_cycles and of the internal dead-band counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  channel enable; low forces both outputs low
- cnt  in  CNT_WIDTH  timebase counter, 0..period-1
- period_end  in  1  timebase pulse, high during the last cycle of each period
- duty_cycles  in  CNT_WIDTH  requested high time in clocks
- dead_cycles  in  DT_WIDTH  dead band in clocks; 0 means no dead band
- pwm_raw  out  1  registered compare result, before dead time
- pwm_h  out  1  high-side drive
- pwm_l  out  1  low-side drive
- duty_active  out  CNT_WIDTH  shadow duty currently in use

Behaviour:
- Reset values: duty_active=0, pwm_raw=0, pwm_h=0, pwm_l=0, FSM=S_OFF, dead-band counter=0.
- Shadow duty: duty_active loads duty_cycles on any edge where enable=0, or where enable=1 and period_end=1. Otherwise it holds. A new duty therefore never changes the current period mid-way.
- Compare: pwm_raw <= enable && (cnt < duty_active), unsigned compare, one clock of latency from cnt.
  - duty_active=0 gives 0%.
  - duty_active >= period gives 100%, because cnt < period always holds. No separate clamp exists.
- The edge that loads a new shadow at period_end also evaluates cnt=period-1 against the old duty. The new duty first governs the compare of cnt=0.
- FSM states: S_OFF, S_DEAD_TO_HIGH, S_HIGH, S_DEAD_TO_LOW, S_LOW. Outputs are registered, Moore from state: pwm_h=1 only in S_HIGH, pwm_l=1 only in S_LOW, both 0 otherwise.
- Transitions, with enable=1:
  - S_OFF -> S_DEAD_TO_HIGH if pwm_raw=1, else S_DEAD_TO_LOW. The dead band is enforced even when starting from off.
  - S_LOW with pwm_raw=1 -> S_DEAD_TO_HIGH.
  - S_HIGH with pwm_raw=0 -> S_DEAD_TO_LOW.
  - Entering a dead state loads the counter with dead_cycles, sampled at that edge. The state then lasts exactly dead_cycles clocks before moving to S_HIGH or S_LOW.
  - dead_cycles=0 skips the dead state: the transition goes directly to S_HIGH or S_LOW in one clock.
  - If pwm_raw reverts during a dead state, abort and go to the opposite target state next clock. Example: in S_DEAD_TO_HIGH with pwm_raw=0 -> S_LOW. This is safe because both outputs were low during the dead state.
- Latency: pwm_raw rising at cycle t gives pwm_l=0 at t+1 and pwm_h=1 at t+1+dead_cycles.
- enable=0: any state -> S_OFF on the next edge, both outputs 0 and the counter cleared. pwm_raw goes 0 on the same edge.
- Invariant: pwm_h && pwm_l is never 1 in any cycle, including during reset and disable.
- Reset asserted mid-operation: all outputs go 0 immediately (asynchronous), with no glitch to 1.

Optional Feature:
- Macro: PWM_DEADTIME_FAULT_EN.
- When defined:
  - Adds input fault_in (1 bit) and output fault_latched (1 bit, reset 0).
  - fault_in=1 sets fault_latched on the next edge; it is sticky.
  - While fault_latched=1, the FSM is forced to S_OFF and pwm_h=pwm_l=0.
  - fault_latched clears only on an edge with enable=0 and fault_in=0.
  - The FSM then restarts from S_OFF through a full dead band.
- When undefined: the ports are absent and the behaviour is exactly as above.

Decomposition:
- Package pwm_pkg holds the FSM enum pwm_dt_state_t (the five states) and localparam widths shared with the timebase (CNT_WIDTH default).
- One natural sub-module is pwm_deadtime_gen: the FSM plus dead-band counter, taking pwm_raw, enable and dead_cycles and producing pwm_h and pwm_l.
- The top level holds the shadow register and the comparator.

Test Plan:
- Timebase period 10, duty 4, dead 0, enable=1:
  - pwm_raw high 4 of every 10 cycles.
  - pwm_h high 4 and pwm_l high 6 per period.
  - Outputs are exact complements one cycle after pwm_raw.
- Period 10, duty 4, dead 2:
  - pwm_h high 2 per period, pwm_l high 4 per period.
  - Exactly 2 both-low cycles at each transition.
  - pwm_h && pwm_l never 1 (concurrent assertion).
- Change duty from 4 to 7 when cnt=3:
  - Current period keeps 4 high cycles; the next period starts with 7.
  - duty_active updates on the period_end edge.
- Boundaries with period 10, dead 0:
  - duty 0: pwm_raw constant 0, pwm_l constant 1.
  - duty 10 and duty 15: pwm_raw constant 1, pwm_h constant 1.
- Period 10, duty 1, dead 3:
  - pwm_raw pulse shorter than the dead band, so S_DEAD_TO_HIGH aborts to S_LOW.
  - pwm_h never asserts; the bench checks both-low cycles.
- Drop enable mid-pulse:
  - Next edge: pwm_h=pwm_l=0 and duty_active tracks duty_cycles.
  - Re-enable: both outputs stay low for dead_cycles before the first drive.
  - Pulse rst mid-period: all outputs 0 immediately.
